// File: rtl/aes_byte_packer.sv
// Byte-to-block packer in front of an AES-128 core: gathers 16 bytes into a
// 128-bit word and hands it over either as a key load or as a data block.
module aes_byte_packer (
  input  logic         clk,
  input  logic         rstn,
  input  logic         s_valid,
  input  logic [7:0]   s_data,
  input  logic         s_is_key,
  input  logic         s_abort,
  output logic         s_ready,
  input  logic         rk_ready,
  output logic [127:0] key_out,
  output logic         key_load,
  output logic [127:0] blk_out,
  output logic         blk_valid,
  output logic [4:0]   byte_cnt
);

  localparam logic [1:0] FILL      = 2'd0;
  localparam logic [1:0] EMIT_KEY  = 2'd1;
  localparam logic [1:0] WAIT_RK   = 2'd2;
  localparam logic [1:0] HOLD_DATA = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [4:0]   cnt_q, cnt_d;
  logic         kind_q, kind_d;
  logic         wait_first_q, wait_first_d;
  logic [127:0] shreg_q, shreg_d;
  logic [127:0] key_q, key_d;
  logic [127:0] blk_q, blk_d;
  logic         hs_s;

  // Handshake qualifiers and pulse outputs; pulses are forced low while in reset.
  always_comb begin
    s_ready   = rstn && (state_q == FILL);
    hs_s      = s_valid && s_ready;
    key_load  = rstn && (state_q == EMIT_KEY);
    blk_valid = rstn && (state_q == HOLD_DATA) && rk_ready;
    byte_cnt  = cnt_q;
  end

  // Word outputs track the shift register during their pulse and hold afterwards.
  always_comb begin
    if (key_load) begin
      key_out = shreg_q;
    end else begin
      key_out = key_q;
    end
    if (blk_valid) begin
      blk_out = shreg_q;
    end else begin
      blk_out = blk_q;
    end
  end

  // Next-state logic for the packing FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    kind_d       = kind_q;
    wait_first_d = wait_first_q;
    shreg_d      = shreg_q;
    key_d        = key_q;
    blk_d        = blk_q;
    case (state_q)
      FILL: begin
        // Abort wins over a byte offered in the same cycle.
        if (s_abort) begin
          cnt_d = 5'd0;
        end else if (hs_s) begin
          shreg_d = {shreg_q[119:0], s_data};
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'd0) begin
            kind_d = s_is_key;
          end else begin
            kind_d = kind_q;
          end
          if (cnt_q == 5'd15) begin
            if (kind_q) begin
              state_d = EMIT_KEY;
            end else begin
              state_d = HOLD_DATA;
            end
          end else begin
            state_d = FILL;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      EMIT_KEY: begin
        key_d        = shreg_q;
        wait_first_d = 1'b1;
        state_d      = WAIT_RK;
      end
      WAIT_RK: begin
        // The core drops rk_ready a cycle after the load; ignore the stale level.
        if (wait_first_q) begin
          wait_first_d = 1'b0;
        end else if (rk_ready) begin
          state_d = FILL;
          cnt_d   = 5'd0;
        end else begin
          state_d = WAIT_RK;
        end
      end
      HOLD_DATA: begin
        if (rk_ready) begin
          blk_d   = shreg_q;
          state_d = FILL;
          cnt_d   = 5'd0;
        end else begin
          state_d = HOLD_DATA;
        end
      end
      default: begin
        state_d = FILL;
        cnt_d   = 5'd0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= FILL;
      cnt_q        <= 5'd0;
      kind_q       <= 1'b0;
      wait_first_q <= 1'b0;
      shreg_q      <= 128'd0;
      key_q        <= 128'd0;
      blk_q        <= 128'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      kind_q       <= kind_d;
      wait_first_q <= wait_first_d;
      shreg_q      <= shreg_d;
      key_q        <= key_d;
      blk_q        <= blk_d;
    end
  end

endmodule

// File: tb/tb_aes_byte_packer.sv
// Directed self-checking bench for aes_byte_packer with hand-computed vectors.
module tb_aes_byte_packer;

  logic         clk;
  logic         rstn;
  logic         s_valid;
  logic [7:0]   s_data;
  logic         s_is_key;
  logic         s_abort;
  logic         s_ready;
  logic         rk_ready;
  logic [127:0] key_out;
  logic         key_load;
  logic [127:0] blk_out;
  logic         blk_valid;
  logic [4:0]   byte_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int key_cnt = 0;
  int blk_cnt = 0;
  int both_cnt = 0;
  int last_blk_cyc = 0;
  int prev_blk_cyc = 0;
  logic [127:0] last_blk_val = 128'd0;
  logic [127:0] prev_blk_val = 128'd0;

  localparam logic [127:0] V_KEY  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] V_D1   = 128'hd7e5dbd3324595f8fdc7d7c571da6c2a;
  localparam logic [127:0] V_D2   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V_D3   = 128'ha2f4dbd3324595f8fdc7d7c571da6c2b;
  localparam logic [127:0] V_D4   = 128'hfedcba98765432100123456789abcdef;
  localparam logic [127:0] V_JUNK = 128'h55aa55aa55aa55aa55aa55aa55aa55aa;

  aes_byte_packer dut (
    .clk       (clk),
    .rstn      (rstn),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_is_key  (s_is_key),
    .s_abort   (s_abort),
    .s_ready   (s_ready),
    .rk_ready  (rk_ready),
    .key_out   (key_out),
    .key_load  (key_load),
    .blk_out   (blk_out),
    .blk_valid (blk_valid),
    .byte_cnt  (byte_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (key_load) key_cnt = key_cnt + 1;
    if (blk_valid) begin
      blk_cnt      = blk_cnt + 1;
      prev_blk_cyc = last_blk_cyc;
      prev_blk_val = last_blk_val;
      last_blk_cyc = cyc;
      last_blk_val = blk_out;
    end
    if (key_load && blk_valid) both_cnt = both_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed=%h required=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer n bytes of v (MSB first), waiting for s_ready on each; s_valid left high.
  task automatic feed_n(input logic [127:0] v, input int n, input logic key);
    for (int i = 0; i < n; i++) begin
      int g;
      s_valid  = 1'b1;
      s_data   = v[127-8*i -: 8];
      s_is_key = (i == 0) ? key : ~key;
      g = 0;
      while (!s_ready && g < 40) begin
        tick();
        g++;
      end
      check_eq("hs_ready", {127'd0, s_ready}, 128'd1);
      tick();
    end
  endtask

  initial begin
    int base;
    int bad;
    rstn = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_is_key = 1'b0;
    s_abort = 1'b0; rk_ready = 1'b0;
    tick(); tick();
    @(negedge clk);
    check_eq("rst_s_ready",   {127'd0, s_ready}, 128'd0);
    check_eq("rst_byte_cnt",  {123'd0, byte_cnt}, 128'd0);
    check_eq("rst_key_out",   key_out, 128'd0);
    check_eq("rst_blk_out",   blk_out, 128'd0);
    check_eq("rst_pulses",    {126'd0, key_load, blk_valid}, 128'd0);
    tick();
    rstn = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready", {127'd0, s_ready}, 128'd1);
    tick();

    // Key load, round keys not yet ready.
    feed_n(V_KEY, 16, 1'b1);
    s_valid = 1'b0;
    @(negedge clk);
    check_eq("key_load",     {127'd0, key_load}, 128'd1);
    check_eq("key_out",      key_out, V_KEY);
    check_eq("key_cnt16",    {123'd0, byte_cnt}, 128'd16);
    check_eq("key_no_blk",   {127'd0, blk_valid}, 128'd0);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      if (s_ready || key_load || byte_cnt != 5'd16) bad++;
    end
    check_eq("wait_rk_quiet", 128'(bad), 128'd0);
    tick();
    rk_ready = 1'b1;
    @(negedge clk);
    check_eq("wait_rk_ready0", {127'd0, s_ready}, 128'd0);
    tick();
    @(negedge clk);
    check_eq("key_back_fill", {127'd0, s_ready}, 128'd1);
    check_eq("key_cnt0",      {123'd0, byte_cnt}, 128'd0);
    check_eq("key_hold",      key_out, V_KEY);
    check_eq("key_one_pulse", 128'(key_cnt), 128'd1);
    tick();

    // Data block with rk_ready high; s_is_key=1 on bytes 1..15 must be ignored.
    feed_n(V_D1, 16, 1'b0);
    s_valid = 1'b0;
    @(negedge clk);
    check_eq("d1_valid", {127'd0, blk_valid}, 128'd1);
    check_eq("d1_blk",   blk_out, V_D1);
    check_eq("d1_nokey", {127'd0, key_load}, 128'd0);
    tick();
    @(negedge clk);
    check_eq("d1_valid_off", {127'd0, blk_valid}, 128'd0);
    check_eq("d1_ready",     {127'd0, s_ready}, 128'd1);
    check_eq("d1_blk_hold",  blk_out, V_D1);
    tick();

    // Data block held five cycles for round keys.
    rk_ready = 1'b0;
    base = blk_cnt;
    feed_n(V_D2, 16, 1'b0);
    s_valid = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (blk_valid || s_ready) bad++;
      tick();
    end
    check_eq("d2_wait_quiet", 128'(bad), 128'd0);
    rk_ready = 1'b1;
    @(negedge clk);
    check_eq("d2_valid", {127'd0, blk_valid}, 128'd1);
    check_eq("d2_blk",   blk_out, V_D2);
    tick();
    @(negedge clk);
    check_eq("d2_one_pulse", 128'(blk_cnt - base), 128'd1);
    tick();

    // Abort after seven bytes, with a byte offered in the abort cycle.
    feed_n(V_JUNK, 7, 1'b0);
    s_valid = 1'b0;
    @(negedge clk);
    check_eq("abort_cnt7", {123'd0, byte_cnt}, 128'd7);
    tick();
    s_valid = 1'b1; s_abort = 1'b1; s_data = 8'h5a;
    tick();
    s_valid = 1'b0; s_abort = 1'b0;
    @(negedge clk);
    check_eq("abort_cnt0", {123'd0, byte_cnt}, 128'd0);
    tick();
    feed_n(V_D3, 16, 1'b0);
    s_valid = 1'b0;
    @(negedge clk);
    check_eq("abort_blk", blk_out, V_D3);
    tick();

    // Back-to-back data blocks with s_valid held high.
    base = blk_cnt;
    feed_n(V_D1, 16, 1'b0);
    feed_n(V_D3, 16, 1'b0);
    s_valid = 1'b0;
    tick();
    @(negedge clk);
    check_eq("b2b_pulses", 128'(blk_cnt - base), 128'd2);
    check_eq("b2b_period", 128'(last_blk_cyc - prev_blk_cyc), 128'd17);
    check_eq("b2b_first",  prev_blk_val, V_D1);
    check_eq("b2b_second", last_blk_val, V_D3);
    tick();

    // Reset after ten bytes, then a fresh block.
    feed_n(V_D2, 10, 1'b0);
    s_valid = 1'b0;
    rstn = 1'b0;
    tick(); tick();
    @(negedge clk);
    check_eq("mid_rst_ready", {127'd0, s_ready}, 128'd0);
    check_eq("mid_rst_cnt",   {123'd0, byte_cnt}, 128'd0);
    check_eq("mid_rst_blk",   blk_out, 128'd0);
    tick();
    rstn = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_ready1", {127'd0, s_ready}, 128'd1);
    base = blk_cnt;
    tick();
    feed_n(V_D4, 16, 1'b0);
    s_valid = 1'b0;
    @(negedge clk);
    check_eq("rst_new_blk", blk_out, V_D4);
    tick(); tick();
    check_eq("rst_new_pulses", 128'(blk_cnt - base), 128'd1);

    // Reset while waiting for round keys.
    rk_ready = 1'b0;
    base = key_cnt;
    feed_n(V_KEY, 16, 1'b1);
    s_valid = 1'b0;
    tick(); tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    rk_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    check_eq("wrk_rst_key",    key_out, 128'd0);
    check_eq("wrk_rst_pulses", 128'(key_cnt - base), 128'd1);
    check_eq("wrk_rst_ready",  {127'd0, s_ready}, 128'd1);
    check_eq("no_overlap",     128'(both_cnt), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_byte_packer.md
AES_BYTE_PACKER -- requirements
Module: aes_byte_packer

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset; clock `clk`, reset `rstn`. All state changes on the rising edge of `clk`.
REQ-002 `clk`  in  1  system clock.
REQ-003 `rstn`  in  1  synchronous active-low reset.
REQ-004 `s_valid`  in  1  upstream byte valid.
REQ-005 `s_data`  in  8  upstream byte.
REQ-006 `s_is_key`  in  1  sideband: block being started is a key; sampled on byte 0 only.
REQ-007 `s_abort`  in  1  discard the partial block.
REQ-008 `s_ready`  out  1  packer accepts a byte this cycle.
REQ-009 `rk_ready`  in  1  from AES128: round keys are ready.
REQ-010 `key_out`  out  128  assembled key, drives AES128 `key_in`.
REQ-011 `key_load`  out  1  single-cycle pulse, drives AES128 `en`.
REQ-012 `blk_out`  out  128  assembled plaintext/ciphertext, drives AES128 `data_in`.
REQ-013 `blk_valid`  out  1  single-cycle pulse, drives AES128 `data_in_valid`.
REQ-014 `byte_cnt`  out  5  bytes held in the current partial block (0..16).

Function
REQ-015 A byte handshake SHALL occur when `s_valid`=1 and `s_ready`=1.
REQ-016 Byte packing: `shreg` <= {`shreg`[119:0], `s_data`}. The first byte of a block lands in bits [127:120] and the 16th in [7:0].
REQ-017 States SHALL be FILL, EMIT_KEY, WAIT_RK, HOLD_DATA.
REQ-018 `s_ready`=1 only in FILL.
REQ-019 FILL: each handshake increments `byte_cnt`. On the handshake with `byte_cnt`=15, the next state is EMIT_KEY if the latched kind flag is key, otherwise HOLD_DATA.
REQ-020 The kind flag SHALL be latched from `s_is_key` on the handshake with `byte_cnt`=0. `s_is_key` on bytes 1..15 is ignored.
REQ-021 EMIT_KEY (one cycle): `key_out` <= `shreg`, `key_load`=1, next state WAIT_RK.
REQ-022 WAIT_RK: `rk_ready` is ignored in the first cycle. From the second cycle on, `rk_ready`=1 moves the state to FILL with `byte_cnt`=0.
REQ-023 HOLD_DATA: while `rk_ready`=0, remain in HOLD_DATA. In the first cycle with `rk_ready`=1: `blk_out` <= `shreg`, `blk_valid`=1 in that same cycle, next state FILL with `byte_cnt`=0.
REQ-024 `blk_out` and `blk_valid` SHALL be consistent in the same cycle: either drive `blk_out` combinationally from `shreg` while `blk_valid`=1, or register both one cycle later. The chosen form applies identically to `key_out`/`key_load`.
REQ-025 `key_out` and `blk_out` SHALL hold their last value between pulses.
REQ-026 Latency: the earliest `blk_valid` is 1 cycle after the 16th byte handshake when `rk_ready`=1. The earliest `key_load` is 1 cycle after the 16th byte handshake.
REQ-027 Throughput: back-to-back data blocks SHALL be accepted at 17 cycles per block maximum.
REQ-028 `s_abort`=1 in FILL: clear `byte_cnt` to 0 and discard any byte handshaked in the same cycle (abort wins).
REQ-029 `s_abort` in EMIT_KEY, WAIT_RK or HOLD_DATA SHALL be ignored.
REQ-030 `key_load` and `blk_valid` SHALL never be 1 in the same cycle.
REQ-031 Each outputs at most one pulse per assembled block.
REQ-032 `byte_cnt` SHALL read 16 in EMIT_KEY, WAIT_RK and HOLD_DATA.

Reset
REQ-033 `rstn`=0 at a clock edge SHALL force FILL, `byte_cnt`=0, kind flag=0, `shreg`=0, `key_out`=0, `blk_out`=0, `key_load`=0, `blk_valid`=0 and `s_ready`=0 during reset.
REQ-034 `s_ready`=1 in the first cycle after `rstn` returns high.
REQ-035 Reset mid-block or mid-WAIT_RK SHALL discard all partial state; no pulse is emitted afterwards for that block.

Verification
REQ-036 Key load: bytes 01,23,45,67,89,AB,CD,EF repeated twice, with `s_is_key`=1 on byte 0 -> `key_out`=0123456789ABCDEF0123456789ABCDEF, `key_load` high exactly 1 cycle, `s_ready`=0 until `rk_ready`=1.
REQ-037 Data with `rk_ready`=1: bytes D7,E5,DB,D3,32,45,95,F8,FD,C7,D7,C5,71,DA,6C,2A -> `blk_valid` 1 cycle after byte 16, `blk_out`=d7e5dbd3324595f8fdc7d7c571da6c2a.
REQ-038 Data with `rk_ready`=0 for 5 cycles after byte 16 -> `blk_valid` pulses once, in the first cycle `rk_ready`=1; `s_ready`=0 throughout the wait.
REQ-039 Abort: 7 bytes, then `s_abort`=1 together with a valid byte -> `byte_cnt`=0. Then 16 bytes of a2f4dbd3324595f8fdc7d7c571da6c2b -> `blk_out` equals exactly that value.
REQ-040 Two consecutive data blocks with `s_valid` held high and `rk_ready`=1 -> two `blk_valid` pulses 17 cycles apart, with correct values.
REQ-041 `rstn`=0 after 10 bytes, then 16 new bytes -> no stale pulse, and `blk_out` equals only the new bytes.
